// File: rtl/riscv_pkg.sv
// Shared core-wide parameters.
package riscv_pkg;
    localparam int XLEN     = 32;
    localparam int RAS_SIZE = 8;
endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch-side call/ret handshake into the RAS speculation controller.
interface ras_ctrl_if;
    import riscv_pkg::*;

    logic            fe_valid;
    logic            fe_is_call;
    logic            fe_is_ret;
    logic [XLEN-1:0] fe_link_addr;
    logic            fe_ready;
    logic [XLEN-1:0] fe_pred_target;
    logic            fe_pred_valid;

    modport master (
        output fe_valid, fe_is_call, fe_is_ret, fe_link_addr,
        input  fe_ready, fe_pred_target, fe_pred_valid
    );

    modport slave (
        input  fe_valid, fe_is_call, fe_is_ret, fe_link_addr,
        output fe_ready, fe_pred_target, fe_pred_valid
    );
endinterface

// File: rtl/ras_ctrl.sv
// RAS speculation controller: undo log of speculative push/pop, youngest-first replay on flush.
// Optional counters enabled by defining RAS_CTRL_STATS_EN.
module ras_ctrl
    import riscv_pkg::*;
#(
    parameter int LOG_DEPTH = 8,
    parameter int LOG_PTR_W = $clog2(LOG_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    ras_ctrl_if.slave       fe,
    input  logic            cm_valid,
    input  logic            flush,
    output logic            busy,
    output logic            ras_push,
    output logic            ras_pop,
    output logic [XLEN-1:0] ras_return_addr,
    input  logic [XLEN-1:0] ras_predicted_return,
    input  logic            ras_valid,
    output logic [31:0]     stat_undo_ops,
    output logic [31:0]     stat_stall_cycles
);

    typedef enum logic {RUN, UNDO} state_t;

    localparam logic [1:0] K_PUSH = 2'd0;
    localparam logic [1:0] K_POP  = 2'd1;
    localparam logic [1:0] K_SWAP = 2'd2;

    localparam logic [LOG_PTR_W:0] FULL = (LOG_PTR_W+1)'(LOG_DEPTH);

    state_t               state;
    logic [LOG_PTR_W-1:0] head;
    logic [LOG_PTR_W-1:0] tail;
    logic [LOG_PTR_W:0]   cnt;

    logic [1:0]      log_kind [LOG_DEPTH];
    logic            log_had  [LOG_DEPTH];
    logic [XLEN-1:0] log_addr [LOG_DEPTH];

    logic            u_push;
    logic            u_pop;
    logic [XLEN-1:0] u_addr;

    logic                 is_run;
    logic                 ev;
    logic                 acc;
    logic                 cm_eff;
    logic [LOG_PTR_W:0]   cnt_cm;
    logic [LOG_PTR_W-1:0] yidx;
    logic                 inv_push;
    logic                 inv_pop;

    assign is_run = (state == RUN);
    assign ev     = fe.fe_valid & (fe.fe_is_call | fe.fe_is_ret);
    assign fe.fe_ready = is_run & ~flush & ((cnt < FULL) | cm_valid);
    assign acc    = ev & fe.fe_ready;
    assign cm_eff = is_run & cm_valid & (cnt != '0);
    assign cnt_cm = cnt - (LOG_PTR_W+1)'(cm_eff);
    assign yidx   = tail - 1'b1;
    assign busy   = ~is_run;

    assign fe.fe_pred_valid  = fe.fe_valid & fe.fe_is_ret & ras_valid & is_run;
    assign fe.fe_pred_target = fe.fe_pred_valid ? ras_predicted_return : '0;

    // Inverse of the youngest logged op
    always_comb begin
        inv_push = 1'b0;
        inv_pop  = 1'b0;
        unique case (log_kind[yidx])
            K_PUSH: inv_pop = 1'b1;
            K_POP:  inv_push = log_had[yidx];
            K_SWAP: begin
                inv_push = log_had[yidx];
                inv_pop  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ras_push        = u_push;
        ras_pop         = u_pop;
        ras_return_addr = u_addr;
        if (is_run) begin
            ras_push        = acc & fe.fe_is_call;
            ras_pop         = acc & fe.fe_is_ret;
            ras_return_addr = (acc & fe.fe_is_call) ? fe.fe_link_addr : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            log_kind[tail] <= fe.fe_is_call ? (fe.fe_is_ret ? K_SWAP : K_PUSH) : K_POP;
            log_had[tail]  <= ras_valid;
            log_addr[tail] <= ras_predicted_return;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            u_push <= 1'b0;
            u_pop  <= 1'b0;
            u_addr <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    head <= head + LOG_PTR_W'(cm_eff);
                    if (flush) begin
                        if (cnt_cm != '0) begin
                            state  <= UNDO;
                            u_push <= inv_push;
                            u_pop  <= inv_pop;
                            u_addr <= inv_push ? log_addr[yidx] : '0;
                            tail   <= yidx;
                            cnt    <= cnt_cm - 1'b1;
                        end else begin
                            cnt <= cnt_cm;
                        end
                    end else begin
                        tail <= tail + LOG_PTR_W'(acc);
                        cnt  <= cnt_cm + (LOG_PTR_W+1)'(acc);
                    end
                end
                UNDO: begin
                    if (cnt != '0) begin
                        u_push <= inv_push;
                        u_pop  <= inv_pop;
                        u_addr <= inv_push ? log_addr[yidx] : '0;
                        tail   <= yidx;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        state  <= RUN;
                        u_push <= 1'b0;
                        u_pop  <= 1'b0;
                        u_addr <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(cm_valid && state == UNDO));
            assert (!(cm_valid && state == RUN && cnt == '0));
        end
    end

`ifdef RAS_CTRL_STATS_EN
    logic undo_op;
    logic stall;

    assign undo_op = ~is_run & (ras_push | ras_pop);
    assign stall   = ev & ~fe.fe_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_undo_ops     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (undo_op && stat_undo_ops != '1)
                stat_undo_ops <= stat_undo_ops + 1'b1;
            if (stall && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`else
    assign stat_undo_ops     = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl.
module tb_ras_ctrl;
    import riscv_pkg::*;

    logic            clk;
    logic            reset;
    logic            cm_valid;
    logic            flush;
    logic            busy;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_return_addr;
    logic [XLEN-1:0] ras_predicted_return;
    logic            ras_valid;
    logic [31:0]     stat_undo_ops;
    logic [31:0]     stat_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    ras_ctrl_if fe_bus ();

    ras_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .fe                   (fe_bus.slave),
        .cm_valid             (cm_valid),
        .flush                (flush),
        .busy                 (busy),
        .ras_push             (ras_push),
        .ras_pop              (ras_pop),
        .ras_return_addr      (ras_return_addr),
        .ras_predicted_return (ras_predicted_return),
        .ras_valid            (ras_valid),
        .stat_undo_ops        (stat_undo_ops),
        .stat_stall_cycles    (stat_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fe();
        fe_bus.fe_valid     = 1'b0;
        fe_bus.fe_is_call   = 1'b0;
        fe_bus.fe_is_ret    = 1'b0;
        fe_bus.fe_link_addr = '0;
    endtask

    task automatic do_reset();
        idle_fe();
        cm_valid = 1'b0;
        flush = 1'b0;
        ras_valid = 1'b0;
        ras_predicted_return = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic call(input logic [XLEN-1:0] a);
        fe_bus.fe_valid     = 1'b1;
        fe_bus.fe_is_call   = 1'b1;
        fe_bus.fe_is_ret    = 1'b0;
        fe_bus.fe_link_addr = a;
    endtask

    task automatic ret();
        fe_bus.fe_valid   = 1'b1;
        fe_bus.fe_is_call = 1'b0;
        fe_bus.fe_is_ret  = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_ready", fe_bus.fe_ready, 1);
        chk("rst_push", ras_push, 0);
        chk("rst_pop", ras_pop, 0);
        chk("rst_addr", ras_return_addr, 0);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_stat_u", stat_undo_ops, 0);
        chk("rst_stat_s", stat_stall_cycles, 0);

        // single call
        call(32'h100);
        #1;
        chk("c1_push", ras_push, 1);
        chk("c1_pop", ras_pop, 0);
        chk("c1_addr", ras_return_addr, 32'h100);
        tick();
        idle_fe();
        #1;
        chk("c1_cnt", dut.cnt, 1);
        chk("c1_idle_addr", ras_return_addr, 0);

        // call, call, ret, flush -> 3 undo cycles
        do_reset();
        call(32'h100);
        tick();
        call(32'h200);
        tick();
        ret();
        ras_valid = 1'b1;
        ras_predicted_return = 32'h200;
        #1;
        chk("r_pred_v", fe_bus.fe_pred_valid, 1);
        chk("r_pred_t", fe_bus.fe_pred_target, 32'h200);
        chk("r_pop", ras_pop, 1);
        chk("r_push", ras_push, 0);
        tick();
        idle_fe();
        flush = 1'b1;
        #1;
        chk("f_ready", fe_bus.fe_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("u1_busy", busy, 1);
        chk("u1_push", ras_push, 1);
        chk("u1_pop", ras_pop, 0);
        chk("u1_addr", ras_return_addr, 32'h200);
        chk("u1_ready", fe_bus.fe_ready, 0);
        tick();
        chk("u2_busy", busy, 1);
        chk("u2_push", ras_push, 0);
        chk("u2_pop", ras_pop, 1);
        tick();
        chk("u3_busy", busy, 1);
        chk("u3_pop", ras_pop, 1);
        tick();
        chk("u_end_busy", busy, 0);
        chk("u_end_ready", fe_bus.fe_ready, 1);
        chk("u_end_cnt", dut.cnt, 0);
        chk("u_end_pop", ras_pop, 0);
`ifdef RAS_CTRL_STATS_EN
        chk("stat_undo3", stat_undo_ops, 3);
`else
        chk("stat_undo0", stat_undo_ops, 0);
`endif

        // fill log, 9th call stalls unless a commit frees a slot
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            call(XLEN'(i * 16));
            tick();
        end
        call(32'h900);
        #1;
        chk("full_ready", fe_bus.fe_ready, 0);
        chk("full_push", ras_push, 0);
        cm_valid = 1'b1;
        #1;
        chk("full_cm_ready", fe_bus.fe_ready, 1);
        chk("full_cm_push", ras_push, 1);
        tick();
        cm_valid = 1'b0;
        idle_fe();
        #1;
        chk("full_cnt", dut.cnt, 8);

        // ret with empty RAS -> no-op undo cycle
        do_reset();
        ret();
        ras_valid = 1'b0;
        ras_predicted_return = 32'h55;
        #1;
        chk("e_pred_v", fe_bus.fe_pred_valid, 0);
        chk("e_pred_t", fe_bus.fe_pred_target, 0);
        chk("e_pop", ras_pop, 1);
        tick();
        idle_fe();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("e_busy", busy, 1);
        chk("e_push", ras_push, 0);
        chk("e_pop_u", ras_pop, 0);
        tick();
        chk("e_end_busy", busy, 0);
        chk("e_end_ready", fe_bus.fe_ready, 1);

        // swap
        do_reset();
        call(32'h400);
        fe_bus.fe_is_ret = 1'b1;
        ras_valid = 1'b1;
        ras_predicted_return = 32'h300;
        #1;
        chk("s_push", ras_push, 1);
        chk("s_pop", ras_pop, 1);
        chk("s_addr", ras_return_addr, 32'h400);
        tick();
        idle_fe();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("su_push", ras_push, 1);
        chk("su_pop", ras_pop, 1);
        chk("su_addr", ras_return_addr, 32'h300);
        tick();
        chk("su_end_busy", busy, 0);

        // flush with same-cycle commit: one undo cycle
        do_reset();
        call(32'h10);
        tick();
        call(32'h20);
        tick();
        idle_fe();
        flush = 1'b1;
        cm_valid = 1'b1;
        tick();
        flush = 1'b0;
        cm_valid = 1'b0;
        #1;
        chk("fc_busy", busy, 1);
        chk("fc_pop", ras_pop, 1);
        chk("fc_push", ras_push, 0);
        tick();
        chk("fc_end_busy", busy, 0);
        chk("fc_end_cnt", dut.cnt, 0);

        // reset mid-undo
        do_reset();
        for (int i = 0; i < 3; i++) begin
            call(XLEN'(32'h40 + i * 4));
            tick();
        end
        idle_fe();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("mr_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mr_busy0", busy, 0);
        chk("mr_cnt0", dut.cnt, 0);
        chk("mr_pop0", ras_pop, 0);
        reset = 1'b0;
        #1;
        chk("mr_ready", fe_bus.fe_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Speculation controller sitting between fetch-stage predecode and the return address stack (ras).
- Turns classified call/return events into ras push/pop/push-and-pop commands.
- Logs every speculative RAS operation in an undo log, retires log entries at commit.
- On a pipeline flush, replays inverse operations youngest-first so the RAS returns to its architectural state, stalling fetch while it does so.

Parameters:
- LOG_DEPTH, 8, undo-log entries (power of 2, >=2); the maximum number of uncommitted call/ret instructions in flight.
- LOG_PTR_W, $clog2(LOG_DEPTH), log pointer width.
- XLEN, RAS_SIZE: taken from riscv_pkg.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fe_valid  in  1  fetch slot holds a valid instruction
- fe_is_call  in  1  instruction is a call (link rd)
- fe_is_ret  in  1  instruction is a return (link rs1); call+ret both high = coroutine swap
- fe_link_addr  in  XLEN  pc+4 of the fetched instruction
- fe_ready  out  1  controller accepts the call/ret this cycle
- fe_pred_target  out  XLEN  predicted return target
- fe_pred_valid  out  1  fe_pred_target usable
- cm_valid  in  1  a call/ret instruction commits this cycle, oldest first
- flush  in  1  squash all uncommitted call/ret instructions
- busy  out  1  undo replay in progress
- ras_push  out  1  to ras push
- ras_pop  out  1  to ras pop
- ras_return_addr  out  XLEN  to ras return_addr
- ras_predicted_return  in  XLEN  from ras predicted_return
- ras_valid  in  1  from ras valid
- stat_undo_ops  out  32  undo operations issued (see optional feature)
- stat_stall_cycles  out  32  cycles with fe_ready=0 (see optional feature)

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous, active-high.
- Reset: state=RUN, log empty (head=tail=0, cnt=0). All outputs 0 except fe_ready=1. Stats are cleared.
- Event definition: accepted event = fe_valid & (fe_is_call | fe_is_ret) & fe_ready.
- RUN, command encoding (combinational, zero latency):
  - call only: ras_push=1, ras_return_addr=fe_link_addr. Log entry {PUSH}.
  - ret only: ras_pop=1. Log entry {POP, had=ras_valid, addr=ras_predicted_return}.
  - call+ret: push=pop=1, ras_return_addr=fe_link_addr. Log entry {SWAP, had=ras_valid, addr=ras_predicted_return}.
  - No accepted event: ras_push=ras_pop=0, ras_return_addr=0.
- fe_ready = (state==RUN) & !flush & (log cnt<LOG_DEPTH, or cm_valid this cycle).
- Prediction: fe_pred_valid = fe_valid & fe_is_ret & ras_valid & (state==RUN); fe_pred_target = ras_predicted_return when valid, else 0.
- Commit: cm_valid retires the oldest entry (head++). cm_valid with an empty log is ignored and fires an assertion.
- Flush in RUN:
  - Same-cycle cm_valid is applied first.
  - The same-cycle fe event is not accepted.
  - If entries remain, next state=UNDO and busy=1; otherwise stay in RUN.
- UNDO: one inverse op per cycle from the youngest entry (tail-1), registered outputs.
  - PUSH -> ras_pop=1.
  - POP with had=1 -> ras_push=1, ras_return_addr=addr.
  - POP with had=0 -> no op, still consumes the cycle.
  - SWAP with had=1 -> push=pop=1, addr.
  - SWAP with had=0 -> ras_pop=1.
  - Decrement tail/cnt each cycle; when cnt reaches 0, return to RUN the following cycle (busy drops with it).
  - Worst-case replay is LOG_DEPTH cycles.
- In UNDO: flush is ignored (all entries are already being undone). cm_valid must be 0 (assertion). fe_ready=0.
- Pointers: head/tail wrap modulo LOG_DEPTH; cnt is LOG_PTR_W+1 bits.
- Simultaneous accept and commit with the log full is legal; cnt is unchanged.
- Reset mid-UNDO: replay is abandoned, log is cleared, state=RUN. The RAS is reset by the same signal.
- Accepted limitation: a push while the RAS is full overwrites the oldest entry; undo cannot restore it.

Optional Feature:
RAS_CTRL_STATS_EN
- Defined: 32-bit saturating counters.
  - stat_undo_ops increments each UNDO cycle that asserts ras_push or ras_pop.
  - stat_stall_cycles increments each cycle with fe_valid & (call|ret) & !fe_ready.
- Undefined: no counter logic; both outputs are tied to 0.

Test Plan:
- Reset, then call with fe_link_addr=0x100 -> same cycle ras_push=1, ras_return_addr=0x100; log cnt=1.
- Calls 0x100 and 0x200, then ret with ras_predicted_return=0x200, then flush -> busy 3 cycles:
  - push 0x200;
  - pop;
  - pop.
  Then RAS empty, fe_ready=1.
- 8 calls without commit, 9th call -> fe_ready=0. With cm_valid in the same cycle -> 9th accepted, cnt stays 8.
- Ret with ras_valid=0 logged, then flush -> one UNDO cycle with no ras_push/ras_pop, then RUN.
- Swap with ras_predicted_return=0x300, link 0x400 -> push=pop=1 addr 0x400. Flush -> push=pop=1 addr 0x300.
- Flush and cm_valid in the same cycle with 2 entries -> only 1 undo cycle. Reset asserted mid-UNDO -> busy=0 and cnt=0 next cycle.
